// File: rtl/sdiv_block.sv
// ---------------------------------------------------------------------------
// sdiv_block
//   Iterative signed divider: q = n / d, r = n % d.
//   Radix-2 restoring division on operand magnitudes, one quotient bit per
//   clock, followed by a sign-fix cycle. The quotient truncates toward zero
//   and the remainder takes the sign of the dividend.
//   Latency from the accepting edge to done is N_W+1 clocks for every operand.
//
// Ports
//   clk    : system clock, all logic on posedge
//   rst_n  : synchronous reset, active low
//   start  : request, sampled only while idle
//   n      : signed dividend (N_W bits), sampled with start
//   d      : signed divisor  (D_W bits), sampled with start
//   busy   : division in progress
//   done   : one-cycle pulse, results valid from this cycle on
//   q      : signed quotient, held until the next done
//   r      : signed remainder, held until the next done
//   div0   : last result had d = 0
//   ovf    : last result was the -2^(N_W-1) / -1 overflow
// ---------------------------------------------------------------------------
module sdiv_block #(
    parameter int unsigned N_W = 48,
    parameter int unsigned D_W = 18
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] q,
    output logic [D_W-1:0] r,
    output logic           div0,
    output logic           ovf
);

    localparam int unsigned CNT_W = $clog2(N_W);

    localparam logic [N_W-1:0] Q_MAX = {1'b0, {(N_W-1){1'b1}}};
    localparam logic [N_W-1:0] Q_MIN = {1'b1, {(N_W-1){1'b0}}};
    localparam logic [D_W-1:0] D_NEG1 = {D_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N_W-1:0]   num;       // dividend magnitude, shifts out MSB-first; quotient shifts in
    logic [N_W-1:0]   rem;       // partial remainder
    logic [D_W-1:0]   dmag;      // divisor magnitude
    logic             n_neg;     // sign of dividend, drives remainder sign
    logic             q_neg;     // sign of quotient
    logic             d_zero;
    logic             n_ovf;

    // Magnitudes are held unsigned: -2^(W-1) maps to 2^(W-1), which is
    // representable in W unsigned bits, so the abs stage cannot wrap.
    logic [N_W-1:0] n_abs_c;
    logic [D_W-1:0] d_abs_c;
    assign n_abs_c = n[N_W-1] ? (~n + N_W'(1)) : n;
    assign d_abs_c = d[D_W-1] ? (~d + D_W'(1)) : d;

    // Special-case detection on the raw operands
    logic d_zero_c;
    logic n_ovf_c;
    assign d_zero_c = (d == '0);
    assign n_ovf_c  = (n == Q_MIN) && (d == D_NEG1);

    // One restoring step: shift {rem, num} left, trial-subtract |d|
    logic [N_W:0] rem_sh_c;
    logic [N_W:0] dmag_ext_c;
    logic         ge_c;
    assign rem_sh_c   = {rem, num[N_W-1]};
    assign dmag_ext_c = (N_W+1)'(dmag);
    assign ge_c       = (rem_sh_c >= dmag_ext_c);

    // Signed results from the magnitudes; |r| < |d| so r fits in D_W bits
    logic [N_W-1:0] q_fix_c;
    logic [D_W-1:0] r_fix_c;
    assign q_fix_c = q_neg ? (~num + N_W'(1)) : num;
    assign r_fix_c = n_neg ? D_W'(~rem + N_W'(1)) : D_W'(rem);

    // Control FSM with registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            num    <= '0;
            rem    <= '0;
            dmag   <= '0;
            n_neg  <= 1'b0;
            q_neg  <= 1'b0;
            d_zero <= 1'b0;
            n_ovf  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            q      <= '0;
            r      <= '0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num    <= n_abs_c;
                        dmag   <= d_abs_c;
                        n_neg  <= n[N_W-1];
                        q_neg  <= n[N_W-1] ^ d[D_W-1];
                        d_zero <= d_zero_c;
                        n_ovf  <= n_ovf_c;
                        rem    <= '0;
                        cnt    <= CNT_W'(N_W-1);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end

                CALC: begin
                    rem <= ge_c ? N_W'(rem_sh_c - dmag_ext_c) : N_W'(rem_sh_c);
                    num <= {num[N_W-2:0], ge_c};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (d_zero) begin
                        q    <= n_neg ? Q_MIN : Q_MAX;
                        r    <= '0;
                        div0 <= 1'b1;
                        ovf  <= 1'b0;
                    end else if (n_ovf) begin
                        q    <= Q_MAX;
                        r    <= '0;
                        div0 <= 1'b0;
                        ovf  <= 1'b1;
                    end else begin
                        q    <= q_fix_c;
                        r    <= r_fix_c;
                        div0 <= 1'b0;
                        ovf  <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdiv_block.sv
// ---------------------------------------------------------------------------
// tb_sdiv_block
//   Scoreboard bench for sdiv_block. Stimulus pushes the expected result and
//   the expected done cycle; a monitor pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_sdiv_block;

    localparam int unsigned N_W = 48;
    localparam int unsigned D_W = 18;
    localparam int unsigned LAT = N_W + 2;   // negedge drive to negedge seeing done

    localparam logic [N_W-1:0] Q_MAX = 48'h7FFF_FFFF_FFFF;
    localparam logic [N_W-1:0] Q_MIN = 48'h8000_0000_0000;

    typedef struct {
        logic [N_W-1:0] q;
        logic [D_W-1:0] r;
        logic           div0;
        logic           ovf;
        int             cyc;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N_W-1:0] n;
    logic [D_W-1:0] d;
    logic           busy;
    logic           done;
    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
    logic           div0;
    logic           ovf;

    int   tests;
    int   fails;
    int   cyc;
    exp_t sb[$];

    sdiv_block #(.N_W(N_W), .D_W(D_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .n     (n),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .div0  (div0),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference using 64-bit signed arithmetic
    function automatic exp_t model(input logic [N_W-1:0] nn, input logic [D_W-1:0] dd);
        exp_t   e;
        longint sn;
        longint sd;
        sn = longint'($signed(nn));
        sd = longint'($signed(dd));
        e.cyc  = 0;
        e.div0 = 1'b0;
        e.ovf  = 1'b0;
        if (sd == 0) begin
            e.q    = (sn >= 0) ? Q_MAX : Q_MIN;
            e.r    = '0;
            e.div0 = 1'b1;
        end else if (nn == Q_MIN && sd == -1) begin
            e.q   = Q_MAX;
            e.r   = '0;
            e.ovf = 1'b1;
        end else begin
            e.q = N_W'(sn / sd);
            e.r = D_W'(sn % sd);
        end
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q",       64'(q),    64'(e.q));
                chk("r",       64'(r),    64'(e.r));
                chk("div0",    64'(div0), 64'(e.div0));
                chk("ovf",     64'(ovf),  64'(e.ovf));
                chk("latency", 64'(cyc),  64'(e.cyc));
            end
        end
    end

    // Called at a negedge; drives a one-cycle start pulse
    task automatic issue(input logic [N_W-1:0] nn, input logic [D_W-1:0] dd,
                         input exp_t e, input bit track);
        exp_t x;
        x = e;
        x.cyc = cyc + LAT;
        start = 1'b1;
        n     = nn;
        d     = dd;
        if (track) sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        if (track) chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_timeout", 64'(seen), 64'd1);
        if (seen) chk("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic op(input logic [N_W-1:0] nn, input logic [D_W-1:0] dd,
                      input logic [N_W-1:0] eq, input logic [D_W-1:0] er,
                      input logic ed0, input logic eov);
        exp_t e;
        e.q = eq; e.r = er; e.div0 = ed0; e.ovf = eov; e.cyc = 0;
        issue(nn, dd, e, 1'b1);
        wait_done();
    endtask

    initial begin
        exp_t e;
        logic [N_W-1:0] rn;
        logic [D_W-1:0] rd;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        n     = '0;
        d     = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q",    64'(q),    64'd0);
        chk("rst_r",    64'(r),    64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and sign matrix
        op(48'(1000),  18'(7),  48'(142),  18'(6),  1'b0, 1'b0);
        op(48'(-1000), 18'(7),  48'(-142), 18'(-6), 1'b0, 1'b0);
        op(48'(1000),  18'(-7), 48'(-142), 18'(6),  1'b0, 1'b0);
        op(48'(-1000), 18'(-7), 48'(142),  18'(-6), 1'b0, 1'b0);

        // Limits
        op(Q_MIN, 18'h3FFFF, Q_MAX, 18'd0, 1'b0, 1'b1);
        op(Q_MIN, 18'd1,     Q_MIN, 18'd0, 1'b0, 1'b0);
        op(48'd5, 18'h20000, 48'd0, 18'd5, 1'b0, 1'b0);

        // Divide by zero
        op(48'd123,   18'd0, Q_MAX, 18'd0, 1'b1, 1'b0);
        op(Q_MAX + Q_MIN, 18'd0, Q_MIN, 18'd0, 1'b1, 1'b0);  // n = -1

        // Handshake: second start during busy must be ignored
        e.q = 48'd3; e.r = 18'd1; e.div0 = 1'b0; e.ovf = 1'b0; e.cyc = 0;
        issue(48'd10, 18'd3, e, 1'b1);
        repeat (5) @(negedge clk);
        issue(48'd99, 18'd9, e, 1'b0);
        wait_done();
        // Start in the done cycle
        e.q = 48'd11; e.r = 18'd0;
        issue(48'd99, 18'd9, e, 1'b1);
        wait_done();

        // Reset in the middle of a division
        issue(48'd1000, 18'd7, e, 1'b0);
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_q",    64'(q),    64'd0);
        chk("abort_r",    64'(r),    64'd0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        op(48'd7, 18'd2, 48'd3, 18'd1, 1'b0, 1'b0);

        // Randomised operands against the reference model
        for (int i = 0; i < 150; i++) begin
            rn = {16'($urandom), $urandom};
            rd = 18'($urandom);
            case ($urandom_range(0, 7))
                0: rd = '0;
                1: rd = 18'h3FFFF;
                2: rn = Q_MIN;
                3: rn = 48'($signed(rd)) * 48'($urandom_range(0, 9));
                default: ;
            endcase
            e = model(rn, rd);
            issue(rn, rd, e, 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
